// File: rtl/hash_squeeze_unpacker.sv
// hash_squeeze_unpacker
//   Unpacks 64-bit Keccak squeeze lanes into a little-endian stream of
//   COEF_W-bit coefficients.  Each coefficient is written zero-extended as a
//   16-bit word to consecutive memory addresses (11-bit wrap).  A job writes
//   NUM_COEF coefficients, then pulses done.
//
//   Optional build macro HASH_UNPACK_REJ_EN: candidates >= MODQ are consumed
//   from the stream but not written, not counted, and do not advance the
//   address.  More lanes are pulled as needed.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           one-cycle pulse: begin/restart a job, latch wr_base_addr
//   wr_base_addr    first write address of the job
//   lane_valid/lane_data/lane_ready   squeeze lane handshake
//   mem_wr_en/mem_wr_addr/mem_wr_data registered memory write port
//   busy            high while a job is running
//   done            one-cycle pulse one cycle after the final write
module hash_squeeze_unpacker #(
    parameter int COEF_W   = 13,
    parameter int NUM_COEF = 64,
    parameter int MODQ     = 7681
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [10:0] wr_base_addr,
    input  logic        lane_valid,
    input  logic [63:0] lane_data,
    output logic        lane_ready,
    output logic        mem_wr_en,
    output logic [10:0] mem_wr_addr,
    output logic [15:0] mem_wr_data,
    output logic        busy,
    output logic        done
);

    localparam int BUF_W = 64 + COEF_W - 1;
    localparam logic [6:0] COEF_W7 = 7'(COEF_W);
    localparam logic [6:0] LAST_CNT = 7'(NUM_COEF - 1);
    localparam logic [COEF_W-1:0] MODQ_C = COEF_W'(MODQ);
`ifdef HASH_UNPACK_REJ_EN
    localparam bit REJ_EN = 1'b1;
`else
    localparam bit REJ_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nxt;

    logic [BUF_W-1:0]  bit_buf;
    logic [6:0]        bit_cnt;
    logic [6:0]        coef_cnt;
    logic [10:0]       addr_q;
    logic [63:0]       swapped;
    logic [COEF_W-1:0] cand;
    logic              accept, emit, keep;

    // First byte delivered by the hash sits in lane_data[63:56]; it becomes
    // the least significant byte of the stream.
    always_comb begin
        swapped = '0;
        for (int i = 0; i < 8; i++)
            swapped[8*i +: 8] = lane_data[8*(7-i) +: 8];
    end

    assign cand   = bit_buf[COEF_W-1:0];
    assign accept = lane_valid & lane_ready;
    assign busy   = (state == RUN);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; start wins from any state
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = RUN;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                RUN:     if (keep && coef_cnt == LAST_CNT) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output / control decode.  Accept and emit are exclusive: a lane is only
    // taken when fewer than COEF_W bits remain.  lane_ready is masked on a
    // start cycle so the source never loses a lane to the buffer clear.
    always_comb begin
        lane_ready = 1'b0;
        emit       = 1'b0;
        keep       = 1'b0;
        if (state == RUN && !start) begin
            lane_ready = (bit_cnt < COEF_W7);
            emit       = (bit_cnt >= COEF_W7);
            keep       = emit && (!REJ_EN || cand < MODQ_C);
        end
    end

    // Datapath and registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_buf     <= '0;
            bit_cnt     <= '0;
            coef_cnt    <= '0;
            addr_q      <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            done        <= 1'b0;
        end else begin
            mem_wr_en <= 1'b0;
            done      <= 1'b0;
            if (start) begin
                bit_buf     <= '0;
                bit_cnt     <= '0;
                coef_cnt    <= '0;
                addr_q      <= wr_base_addr;
                mem_wr_addr <= wr_base_addr;
            end else begin
                if (state == DONE) done <= 1'b1;
                if (accept) begin
                    // bit_cnt < COEF_W here, so the shifted lane fits in BUF_W
                    bit_buf <= bit_buf | (BUF_W'(swapped) << bit_cnt);
                    bit_cnt <= bit_cnt + 7'd64;
                end else if (emit) begin
                    // Rejected candidates are still consumed from the stream
                    bit_buf <= bit_buf >> COEF_W;
                    bit_cnt <= bit_cnt - COEF_W7;
                    if (keep) begin
                        mem_wr_en   <= 1'b1;
                        mem_wr_addr <= addr_q;
                        mem_wr_data <= {{(16-COEF_W){1'b0}}, cand};
                        addr_q      <= addr_q + 11'd1;
                        coef_cnt    <= coef_cnt + 7'd1;
                    end
                end
            end
        end
    end

endmodule
